// File: rtl/dataflow_fifo_pkg.sv
// Shared defaults for the dataflow edge FIFO.
// Define DATAFLOW_FIFO_ERR_EN to add the sticky overflow/underflow flags (off by default).
package dataflow_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/fifo_ram.sv
// Storage array for dataflow_fifo.
// Synchronous write port, asynchronous read port.
module fifo_ram
    import dataflow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dataflow_fifo.sv
// First-word-fall-through FIFO on one dataflow edge.
// DATAFLOW_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module dataflow_fifo
    import dataflow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   population
`ifdef DATAFLOW_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (population == '0);
    assign full    = (population == FULL_CNT);
    assign pop_ok  = rd_in & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot this edge
    assign push_ok = wr_in & (~full | pop_ok);

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign data_out = empty ? '0 : rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            population <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   population <= population + (ADDR_WIDTH+1)'(1);
                2'b01:   population <= population - (ADDR_WIDTH+1)'(1);
                default: population <= population;
            endcase
        end
    end

`ifdef DATAFLOW_FIFO_ERR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (wr_in & ~push_ok);
            underflow <= underflow | (rd_in & empty);
        end
    end
`endif

endmodule

// File: tb/tb_dataflow_fifo.sv
// Randomized and directed bench for dataflow_fifo against a queue model.
// Build with DATAFLOW_FIFO_ERR_EN to also check the sticky error flags.
module tb_dataflow_fifo;
    import dataflow_fifo_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int DP = DEFAULT_DEPTH;
    localparam int AW = DEFAULT_ADDR_WIDTH;

    logic          clock;
    logic          reset;
    logic          wr_in;
    logic [DW-1:0] data_in;
    logic          rd_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [AW:0]   population;
`ifdef DATAFLOW_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
    bit            m_ovf;
    bit            m_unf;
`endif

    int n_chk;
    int n_pass;
    logic [DW-1:0] q[$];

    dataflow_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_in      (wr_in),
        .data_in    (data_in),
        .rd_in      (rd_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .population (population)
`ifdef DATAFLOW_FIFO_ERR_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int sz;
        logic [DW-1:0] head;
        sz   = q.size();
        head = (sz > 0) ? q[0] : '0;
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".full"},  32'(full),  32'(sz == DP));
        check({tag, ".pop"},   32'(population), 32'(sz));
        check({tag, ".dout"},  32'(data_out),   32'(head));
`ifdef DATAFLOW_FIFO_ERR_EN
        check({tag, ".ovf"}, 32'(overflow),  32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`endif
    endtask

    // Drive one cycle, let the edge pass, update the model, compare.
    task automatic cyc(input bit wr, input bit rd, input logic [DW-1:0] d,
                       input string tag);
        bit pop_ok;
        bit push_ok;
        wr_in   = wr;
        rd_in   = rd;
        data_in = d;
        pop_ok  = rd && (q.size() > 0);
        push_ok = wr && ((q.size() < DP) || pop_ok);
`ifdef DATAFLOW_FIFO_ERR_EN
        if (wr && !push_ok) m_ovf = 1'b1;
        if (rd && q.size() == 0) m_unf = 1'b1;
`endif
        @(posedge clock);
        #1;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        wr_in = 1'b0;
        rd_in = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
`ifdef DATAFLOW_FIFO_ERR_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        wr_in   = 1'b0;
        rd_in   = 1'b0;
        data_in = '0;
        reset   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("rst");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("idle");

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, "rd_empty");

        cyc(1'b1, 1'b0, 8'hA5, "single_push");
        check("single_a5", 32'(data_out), 32'hA5);
        cyc(1'b0, 1'b1, '0, "single_pop");

        for (int i = 0; i < DP; i++) cyc(1'b1, 1'b0, DW'(i), "fill");
        check("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'h10, "ovf_push");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, DW'(8'h80 + i), "full_rw");
        check("full_rw_pop", 32'(population), 32'(DP));
        for (int i = 0; i < DP; i++) begin
            if (i < 6) check("drain_head", 32'(data_out), 32'(i + 10));
            cyc(1'b0, 1'b1, '0, "drain");
        end

        cyc(1'b1, 1'b1, 8'h77, "empty_rw");
        check("empty_rw_pop", 32'(population), 32'd1);
        cyc(1'b0, 1'b1, '0, "empty_rw_drain");

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'(i), "wrap_pre");
        for (int i = 0; i < 40; i++) begin
            check("wrap_head", 32'(data_out), 32'(i));
            cyc(1'b1, 1'b1, DW'(i + 3), "wrap");
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, "wrap_drain");

        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, DW'(8'h50 + i), "pre_rst");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clock);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'h3C, "post_rst");
        check("post_rst_3c", 32'(data_out), 32'h3C);
        cyc(1'b0, 1'b1, '0, "post_rst_pop");

        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 250) % 3;
            cyc(($urandom_range(0, 9) < 3 + 2 * bias),
                ($urandom_range(0, 9) < 7 - 2 * bias),
                DW'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dataflow_fifo.md
# dataflow_fifo

Single-clock, first-word-fall-through FIFO that buffers tokens on one dataflow edge between a producer actor and a consumer actor in the polynomial evaluator graph. It sits directly upstream of sink actors such as the file sink. It provides the `data_out` / `empty` / `rd_in` handshake those actors read from, and the `full` / `wr_in` handshake producer actors write into. Population is exported so the main controller can schedule firings.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: token bit width.
- `DEPTH`, default 16: token capacity. Must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default 4: log2(`DEPTH`). Must be kept consistent with `DEPTH`.

Ports:
- `clock`, input, 1: single clock. Rising edge active.
- `reset`, input, 1: asynchronous, active-low reset.
- `wr_in`, input, 1: push request from the producer.
- `data_in`, input, `DATA_WIDTH`: token to push.
- `rd_in`, input, 1: pop request from the consumer.
- `data_out`, output, `DATA_WIDTH`: head token, first-word-fall-through.
- `empty`, output, 1: no tokens held.
- `full`, output, 1: `DEPTH` tokens held.
- `population`, output, `ADDR_WIDTH+1`: current token count, 0..`DEPTH`.
- `overflow`, output, 1: present only with `DATAFLOW_FIFO_ERR_EN`.
- `underflow`, output, 1: present only with `DATAFLOW_FIFO_ERR_EN`.

## Operation
- Storage: circular buffer of `DEPTH` × `DATA_WIDTH`.
- Pointers: `wr_ptr` and `rd_ptr`, each `ADDR_WIDTH` bits. They wrap modulo `DEPTH`.
- Counter: `population` register, `ADDR_WIDTH+1` bits.
- Flags: `empty` = (`population` == 0); `full` = (`population` == `DEPTH`). Both are derived from the registered count.
- Push acceptance: `push_ok = wr_in & (~full | pop_ok)`.
- Pop acceptance: `pop_ok = rd_in & ~empty`.
- Push: write `data_in` at `wr_ptr`, then `wr_ptr`+1.
- Pop: `rd_ptr`+1. Popping does not clear memory.
- Count update:
  - push only: `population` +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- `data_out`:
  - when not empty, equals mem[`rd_ptr`] combinationally.
  - when empty, forced to 0. Consumers never see X on an empty FIFO.
- Full, with both `wr_in` and `rd_in`: both are accepted, pointers advance together, `full` stays 1.
- Empty, with both `wr_in` and `rd_in`: push accepted, pop ignored. There is no bypass. The token becomes visible on the next cycle.
- Write while full without read: dropped. Contents and pointers are unchanged.
- Read while empty: ignored. Contents and pointers are unchanged.
- Reset asserted (low), at any time including mid-burst:
  - pointers and `population` go to 0 immediately.
  - `empty`=1, `full`=0, `data_out`=0.
  - memory contents are not reset.

## Timing
- Push and pop take effect at the `clock` rising edge.
- Outputs are stable for the whole following cycle.
- Write-to-read latency: 1 cycle.
  - A token pushed at edge N appears on `data_out` with `empty`=0 after edge N.
  - It can be popped at edge N+1.
- `rd_in` may be generated combinationally from `~empty` in the same cycle. `data_out` is valid in that cycle and changes after the popping edge.
- Flags and `population` are updated at the edge. They have no combinational path from `wr_in` or `rd_in`.
- Full throughput: one push and one pop per cycle, sustained.

## Configuration
- `DATAFLOW_FIFO_ERR_EN` defined:
  - adds the sticky `overflow` and `underflow` outputs, both reset to 0.
  - `overflow` sets at the edge where `wr_in` is high and the push is rejected.
  - `underflow` sets at the edge where `rd_in` is high and `empty` is high.
  - both clear only on `reset`.
- `DATAFLOW_FIFO_ERR_EN` undefined: those ports and flops are absent. Rejected requests are silently dropped, with identical data behaviour.

## Structure
- Shared package or include holds:
  - default `DATA_WIDTH` and `DEPTH`
  - the log2 helper constant for `ADDR_WIDTH`
  - the `DATAFLOW_FIFO_ERR_EN` default define
- One natural sub-module: `fifo_ram`.
  - `DEPTH`×`DATA_WIDTH` storage array.
  - synchronous write port (`we`, `waddr`, `wdata`).
  - asynchronous read port (`raddr` → `rdata`).
- Pointer, count and flag logic stays in `dataflow_fifo`.

## Test plan
- Reset, then idle:
  - `empty`=1, `full`=0, `population`=0, `data_out`=0.
  - `rd_in`=1 for 3 cycles changes nothing.
  - with `DATAFLOW_FIFO_ERR_EN`, `underflow`=1.
- Single token: push 8'hA5 at edge N.
  - After N: `empty`=0, `data_out`=8'hA5, `population`=1.
  - Pop at N+1: `empty`=1, `data_out`=0.
- Fill and overflow, `DEPTH`=16: push 0..15.
  - `full`=1, `population`=16.
  - A 17th push (8'h10) is dropped.
  - Draining yields 0..15 in order.
  - with `DATAFLOW_FIFO_ERR_EN`, `overflow`=1.
- Simultaneous push and pop:
  - When full, 10 cycles of push/pop: `population` stays 16, output order is preserved.
  - When empty, push+pop for one cycle: `population`=1, pop ignored.
- Wrap-around: 40 push/pop cycles at population 3. The sequence 0..39 comes out intact across 2+ pointer wraps.
- Reset mid-operation: assert `reset` low asynchronously at population 7, mid-cycle.
  - Flags and count clear immediately.
  - After release, the first pushed token 8'h3C is the first one read.
